toggle_bank_arbiter: RTL and testbench

Shares a bank of NCELL clocked toggle cells (T flip-flop behaviour: the cell inverts when toggled, otherwise holds) among NREQ requesters. A round-robin arbiter grants at most one toggle per cycle. Each cell has a per-cell cooldown counter that blocks re-toggling for COOL cycles after a toggle. The block sits between toggle-issuing agents and the cell bank, and is the only path by which the bank changes state.

---
 rtl/toggle_bank_pkg.sv | 49 ++++
 rtl/toggle_bank_arbiter_cell.sv | 49 ++++
 rtl/toggle_bank_arbiter.sv | 112 +++++++++++
 tb/tb_toggle_bank_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_bank_pkg.sv
// Shared definitions for the toggle bank arbiter: defaults, the round-robin
// pick helper and the packed request-index slicer.
package toggle_bank_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int NCELL_DEF = 8;
    localparam int COOL_DEF  = 2;

    // Helpers work on the largest legal configuration; callers zero-extend.
    localparam int MAX_REQ  = 8;
    localparam int MAX_PTRW = 3;
    localparam int MAX_IDXW = 5;
    localparam int PACKED_W = MAX_REQ * MAX_IDXW;

    typedef struct packed {
        logic                found;
        logic [MAX_PTRW-1:0] index;
    } rr_pick_t;

    function automatic int cool_width(input int cool);
        return (cool <= 0) ? 1 : $clog2(cool + 1);
    endfunction

    // First set bit of valid_mask at or after ptr, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid_mask,
                                         input logic [MAX_PTRW-1:0] ptr,
                                         input int                  nreq);
        rr_pick_t            res;
        logic [MAX_PTRW-1:0] sel;
        res = '0;
        for (int off = 0; off < MAX_REQ; off++) begin
            sel = MAX_PTRW'((int'(ptr) + off) % nreq);
            if (off < nreq && !res.found && valid_mask[sel]) begin
                res.found = 1'b1;
                res.index = sel;
            end
        end
        return res;
    endfunction

    function automatic logic [MAX_IDXW-1:0] idx_slice(input logic [PACKED_W-1:0] packed_idx,
                                                      input int                  r,
                                                      input int                  idxw);
        logic [PACKED_W-1:0] mask;
        mask = (PACKED_W'(1) << idxw) - PACKED_W'(1);
        return MAX_IDXW'((packed_idx >> (r * idxw)) & mask);
    endfunction

endpackage

// File: rtl/toggle_bank_arbiter_cell.sv
// One toggle cell: a T flip-flop plus its re-toggle cooldown counter.
// Priority is rst > clr > tog > cooldown decrement.
module toggle_cell
    import toggle_bank_pkg::*;
#(
    parameter int CW = cool_width(COOL_DEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          tog,
    input  logic [CW-1:0] cool_load,
    output logic          q,
    output logic          cooling
);

    logic          q_q, q_d;
    logic [CW-1:0] cool_q, cool_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        q_d    = q_q;
        cool_d = cool_q;
        if (clr) begin
            q_d    = 1'b0;
            cool_d = '0;
        end else if (tog) begin
            q_d    = ~q_q;
            cool_d = cool_load;
        end else if (cool_q != '0) begin
            cool_d = cool_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous, so only clk is in the list.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= 1'b0;
            cool_q <= '0;
        end else begin
            q_q    <= q_d;
            cool_q <= cool_d;
        end
    end

    assign q       = q_q;
    assign cooling = (cool_q != '0);

endmodule

// File: rtl/toggle_bank_arbiter.sv
// Round-robin arbiter granting at most one toggle per cycle into a bank of
// cooldown-protected toggle cells.
module toggle_bank_arbiter
    import toggle_bank_pkg::*;
#(
    parameter int  NREQ  = NREQ_DEF,
    parameter int  NCELL = NCELL_DEF,
    parameter int  COOL  = COOL_DEF,
    localparam int IDXW  = $clog2(NCELL),
    localparam int CW    = cool_width(COOL),
    localparam int GW    = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NCELL-1:0]     q,
    output logic                 grant_valid,
    output logic [GW-1:0]        grant_id,
    output logic                 busy
);

    localparam logic [CW-1:0] COOL_LOAD = CW'(COOL);

    logic [GW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                grant_valid_q, grant_valid_d;
    logic [GW-1:0]       grant_id_q, grant_id_d;

    logic [PACKED_W-1:0] req_idx_ext;
    logic [IDXW-1:0]     tgt_idx [NREQ];
    logic [MAX_REQ-1:0]  elig_mask;
    logic [MAX_PTRW-1:0] ptr_ext;
    rr_pick_t            pick;
    logic [GW-1:0]       winner;
    logic [IDXW-1:0]     win_idx;
    logic [NCELL-1:0]    tog;
    logic [NCELL-1:0]    cooling;

    // A requester aimed at a cooling cell simply drops out of the scan, so
    // it never blocks the requesters behind it.
    always_comb begin
        req_idx_ext                  = '0;
        req_idx_ext[NREQ*IDXW-1:0]   = req_idx;
        elig_mask                    = '0;
        for (int r = 0; r < NREQ; r++) begin
            tgt_idx[r]   = IDXW'(idx_slice(req_idx_ext, r, IDXW));
            elig_mask[r] = req_valid[r] && !cooling[tgt_idx[r]] && !clr && !rst;
        end
        ptr_ext           = '0;
        ptr_ext[GW-1:0]   = rr_ptr_q;
        pick              = rr_pick(elig_mask, ptr_ext, NREQ);
    end

    always_comb begin
        winner    = GW'(pick.index);
        req_ready = '0;
        win_idx   = '0;
        for (int r = 0; r < NREQ; r++) begin
            if (pick.found && pick.index == MAX_PTRW'(r)) begin
                req_ready[r] = 1'b1;
                win_idx      = tgt_idx[r];
            end
        end
        tog = '0;
        if (pick.found) begin
            tog[win_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        grant_valid_d = pick.found;
        if (pick.found) begin
            rr_ptr_d   = (pick.index == MAX_PTRW'(NREQ - 1)) ? '0 : GW'(pick.index + 1'b1);
            grant_id_d = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
        end
    end

    for (genvar i = 0; i < NCELL; i++) begin : g_cell
        toggle_cell #(
            .CW(CW)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .clr       (clr),
            .tog       (tog[i]),
            .cool_load (COOL_LOAD),
            .q         (q[i]),
            .cooling   (cooling[i])
        );
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign busy        = |cooling;

endmodule

// File: tb/tb_toggle_bank_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a time-stamp based model.
module tb_toggle_bank_arbiter;

    localparam int NREQ  = 4;
    localparam int NCELL = 8;
    localparam int COOL  = 2;
    localparam int IDXW  = $clog2(NCELL);
    localparam int GW    = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clr;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      req_ready;
    logic [NCELL-1:0]     q;
    logic                 grant_valid;
    logic [GW-1:0]        grant_id;
    logic                 busy;

    int tests = 0;
    int fails = 0;

    // Model: each cell remembers the edge number of its last toggle; a cell
    // is free once more than COOL edges have passed since then.
    int m_e;
    bit m_q    [NCELL];
    int m_last [NCELL];
    int m_rr;
    bit m_gv;
    int m_gid;
    bit m_known = 1'b0;
    int req_cell [NREQ];
    bit auto_drop = 1'b0;
    int exp_win;

    toggle_bank_arbiter #(
        .NREQ (NREQ),
        .NCELL(NCELL),
        .COOL (COOL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_idx    (req_idx),
        .req_ready  (req_ready),
        .q          (q),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input bit v, input int idx);
        req_valid[r]              = v;
        req_idx[r*IDXW +: IDXW]   = IDXW'(idx);
        req_cell[r]               = idx;
    endtask

    function automatic int model_pick();
        int r;
        if (rst || clr) return -1;
        for (int off = 0; off < NREQ; off++) begin
            r = (m_rr + off) % NREQ;
            if (req_valid[r] && (m_e - m_last[req_cell[r]] > COOL)) return r;
        end
        return -1;
    endfunction

    task automatic model_clear_bank();
        for (int i = 0; i < NCELL; i++) begin
            m_q[i]    = 1'b0;
            m_last[i] = -1000;
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_clear_bank();
            m_rr    = 0;
            m_gv    = 1'b0;
            m_gid   = 0;
            m_known = 1'b1;
        end else if (clr) begin
            model_clear_bank();
            m_gv = 1'b0;
        end else if (exp_win >= 0) begin
            m_q[req_cell[exp_win]]    = ~m_q[req_cell[exp_win]];
            m_last[req_cell[exp_win]] = m_e;
            m_rr  = (exp_win + 1) % NREQ;
            m_gv  = 1'b1;
            m_gid = exp_win;
        end else begin
            m_gv = 1'b0;
        end
        m_e++;
    endtask

    // The single compare point: all outputs checked against the model at
    // the falling edge, then the model advances with the rising edge.
    task automatic step();
        logic [NREQ-1:0]  er;
        logic [NCELL-1:0] eq;
        bit               eb;
        @(negedge clk);
        exp_win = model_pick();
        er = (exp_win >= 0) ? (NREQ'(1) << exp_win) : '0;
        check("req_ready", 32'(req_ready), 32'(er));
        if (m_known) begin
            eq = '0;
            eb = 1'b0;
            for (int i = 0; i < NCELL; i++) begin
                eq[i] = m_q[i];
                if (m_e - m_last[i] <= COOL) eb = 1'b1;
            end
            check("q", 32'(q), 32'(eq));
            check("grant_valid", 32'(grant_valid), 32'(m_gv));
            check("grant_id", 32'(grant_id), 32'(m_gid));
            check("busy", 32'(busy), 32'(eb));
        end
        @(posedge clk);
        #1;
        model_update();
        if (auto_drop && exp_win >= 0) req_valid[exp_win] = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        clr       = 1'b0;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    int rr_seq [5] = '{0, 1, 2, 3, 0};
    logic [NREQ-1:0] cf_ready [4];

    initial begin
        m_e = 0;
        model_clear_bank();
        m_rr  = 0;
        m_gv  = 1'b0;
        m_gid = 0;
        rst   = 1'b1;
        clr   = 1'b0;
        req_valid = '0;
        req_idx   = '0;
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, r);

        // Reset with traffic present, then r0 holds idx 3 through its cooldown.
        step();
        step();
        rst = 1'b0;
        req_valid = '0;
        set_req(0, 1'b1, 3);
        #1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_gv", 32'(grant_valid), 32'h0);
        check("rst_gid", 32'(grant_id), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("first_ready", 32'(req_ready), 32'b0001);
        step();
        check("tog_q", 32'(q), 32'h08);
        check("tog_gv", 32'(grant_valid), 32'h1);
        check("tog_gid", 32'(grant_id), 32'h0);
        check("tog_busy1", 32'(busy), 32'h1);
        check("cool_ready1", 32'(req_ready), 32'h0);
        step();
        check("tog_busy2", 32'(busy), 32'h1);
        check("cool_gv", 32'(grant_valid), 32'h0);
        check("cool_ready2", 32'(req_ready), 32'h0);
        step();
        check("cool_done_busy", 32'(busy), 32'h0);
        check("cool_done_ready", 32'(req_ready), 32'b0001);
        step();
        check("retog_q", 32'(q), 32'h00);
        check("retog_gv", 32'(grant_valid), 32'h1);

        // Round-robin with four distinct held targets.
        do_reset();
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, r);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_gid", 32'(grant_id), 32'(rr_seq[k]));
            check("rr_gv", 32'(grant_valid), 32'h1);
            if (k == 3) check("rr_q4", 32'(q), 32'h0F);
        end
        check("rr_q5", 32'(q), 32'h0E);

        // Conflict on cell 5: r1 is skipped while r2 proceeds.
        do_reset();
        auto_drop = 1'b1;
        set_req(0, 1'b1, 5);
        set_req(1, 1'b1, 5);
        set_req(2, 1'b1, 6);
        cf_ready = '{4'b0001, 4'b0100, 4'b0000, 4'b0010};
        for (int k = 0; k < 4; k++) begin
            #1;
            check("conflict_ready", 32'(req_ready), 32'(cf_ready[k]));
            step();
        end
        check("conflict_gid", 32'(grant_id), 32'h1);
        check("conflict_q", 32'(q), 32'h40);

        // clr right after a toggle aborts its cooldown.
        do_reset();
        set_req(0, 1'b1, 2);
        step();
        check("clr_pre_q", 32'(q), 32'h04);
        clr = 1'b1;
        set_req(1, 1'b1, 2);
        #1;
        check("clr_ready", 32'(req_ready), 32'h0);
        step();
        check("clr_q", 32'(q), 32'h0);
        check("clr_busy", 32'(busy), 32'h0);
        check("clr_gv", 32'(grant_valid), 32'h0);
        clr = 1'b0;
        #1;
        check("post_clr_ready", 32'(req_ready), 32'b0010);
        step();
        check("post_clr_q", 32'(q), 32'h04);
        check("post_clr_gid", 32'(grant_id), 32'h1);

        // Reset in the middle of held traffic.
        auto_drop = 1'b0;
        for (int r = 0; r < NREQ; r++) set_req(r, 1'b1, 4 + r);
        for (int k = 0; k < 3; k++) step();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'h0);
        step();
        check("mid_rst_q", 32'(q), 32'h0);
        check("mid_rst_gv", 32'(grant_valid), 32'h0);
        rst = 1'b0;
        #1;
        check("after_rst_ready", 32'(req_ready), 32'b0001);
        step();
        check("after_rst_gid", 32'(grant_id), 32'h0);

        // Randomized traffic; requesters hold until granted, then drop.
        auto_drop = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] && ($urandom % 3 == 0)) set_req(r, 1'b1, int'($urandom % NCELL));
            end
            rst = ($urandom % 300 == 0);
            clr = ($urandom % 60 == 0);
            step();
        end
        rst = 1'b0;
        clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
